// File: rtl/scan_mux_pkg.sv
// -----------------------------------------------------------------------------
// scan_mux_pkg
// Shared definitions for the scan_mux slice:
//   - MODE_MANUAL / MODE_SCAN : values of the mode input
//   - DEF_NCH / DEF_W         : default channel count and channel width
//   - state_e                 : output-register occupancy (EMPTY / FULL)
//   - next_ptr()              : round-robin successor with an explicit wrap
// Optional feature macro used by the top: SCAN_MUX_PARITY_EN.
// -----------------------------------------------------------------------------
package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int DEF_NCH = 4;
  localparam int DEF_W   = 4;

  // The state bit doubles as out_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Wraps at nch-1 explicitly so non-power-of-two channel counts never
  // visit an index that does not exist.
  function automatic int unsigned next_ptr(input int unsigned cur,
                                           input int unsigned nch);
    return (cur == nch - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/scan_mux_ptr.sv
// -----------------------------------------------------------------------------
// scan_mux_ptr
// Round-robin channel pointer for scan mode.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (ptr -> 0)
//   adv   : step the pointer to the next channel
//   clr   : force the pointer to channel 0; combined with adv the pointer
//           lands on channel 1 (channel 0 is the one being consumed now)
//   ptr   : current channel index, always < NCH
// -----------------------------------------------------------------------------
module scan_mux_ptr
  import scan_mux_pkg::*;
#(
  parameter int NCH = DEF_NCH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   adv,
  input  logic                   clr,
  output logic [$clog2(NCH)-1:0] ptr
);

  localparam int SELW = $clog2(NCH);

  logic [SELW-1:0] base;
  logic [SELW-1:0] ptr_d;

  // NOTE: every variable assigned in always_comb gets a value on all paths
  // before any conditional logic, otherwise synthesis infers a latch.
  always_comb begin
    base  = clr ? '0 : ptr;
    ptr_d = base;
    if (adv) ptr_d = SELW'(next_ptr(32'(base), NCH));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching real flip-flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_d;
  end

endmodule

// File: rtl/scan_mux.sv
// -----------------------------------------------------------------------------
// scan_mux
// Registered NCH-to-1 data multiplexer with a valid/ready output handshake.
// Manual mode picks the channel from sel; scan mode walks the channels
// round-robin, one per captured beat.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, drops any in-flight beat
//   data_in   : NCH*W channel bus, channel c at [c*W +: W]
//   sel       : manual-mode channel select
//   mode      : 0 = manual, 1 = scan
//   en        : capture enable
//   out_data  : registered selected data
//   out_sel   : channel index out_data came from
//   out_valid : out_data/out_sel hold a beat
//   out_par   : even parity of out_data (only with SCAN_MUX_PARITY_EN)
//   out_ready : consumer accepts the beat when out_valid && out_ready
//   sel_err   : one-cycle pulse on a manual capture with sel >= NCH
// Optional feature macro: SCAN_MUX_PARITY_EN.
// -----------------------------------------------------------------------------
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int W    = DEF_W,
  parameter int SELW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*W-1:0]  data_in,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_sel,
  output logic              out_valid,
`ifdef SCAN_MUX_PARITY_EN
  output logic              out_par,
`endif
  input  logic              out_ready,
  output logic              sel_err
);

  state_e          state_q, state_d;
  logic            mode_q;
  logic            mode_scan;
  logic            mode_rise;
  logic            cap;
  logic            sel_bad;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] src;
  logic [W-1:0]    mux_data;

  assign out_valid = (state_q == ST_FULL);
  assign mode_scan = (mode == MODE_SCAN);
  assign mode_rise = mode_scan && (mode_q == MODE_MANUAL);
  // A full register may be refilled in the same cycle it is drained.
  assign cap       = en && (!out_valid || out_ready);
  assign sel_bad   = !mode_scan && (32'(sel) >= NCH);
  // On entry to scan mode the walk restarts at channel 0 without waiting a
  // cycle for the pointer register to clear.
  assign src       = mode_scan ? (mode_rise ? '0 : ptr) : sel;

  scan_mux_ptr #(.NCH(NCH)) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (cap && mode_scan),
    .clr   (mode_rise),
    .ptr   (ptr)
  );

  // Out-of-range indices match no channel and yield zero.
  always_comb begin
    mux_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (32'(src) == c) mux_data = data_in[c*W +: W];
    end
  end

  always_comb begin
    state_d = state_q;
    if (cap)                                 state_d = ST_FULL;
    else if (state_q == ST_FULL && out_ready) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
      sel_err  <= 1'b0;
      mode_q   <= MODE_MANUAL;
    end else begin
      mode_q  <= mode;
      sel_err <= cap && sel_bad;
      if (cap) begin
        out_data <= mux_data;
        out_sel  <= src;
      end
    end
  end

`ifdef SCAN_MUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out_par <= 1'b0;
    else if (cap) out_par <= ^mux_data;
  end
`else
  // Parity output not present in this build.
`endif

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised, registered N-to-1 data multiplexer with a valid/ready output handshake. Successor to the team's combinational 4-to-1 mux.
- Two modes:
  - Manual: the select port picks the channel.
  - Scan: an internal pointer steps round-robin through the channels, one per accepted beat.
- Sits between parallel sensor/data channels and a single serial consumer.

Parameters:
- NCH, 4, number of input channels (>=2).
- W, 4, data width per channel in bits.
- SELW, $clog2(NCH), select/pointer width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- data_in  input  NCH*W  channel c occupies bits [c*W +: W].
- sel  input  SELW  channel select, used in manual mode.
- mode  input  1  0 = manual, 1 = scan.
- en  input  1  capture enable.
- out_data  output  W  registered selected data.
- out_sel  output  SELW  channel index that out_data came from.
- out_valid  output  1  out_data/out_sel hold a beat.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
- sel_err  output  1  1-cycle pulse: manual capture with sel >= NCH.

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - out_data=0, out_sel=0, out_valid=0, sel_err=0.
  - Scan pointer ptr=0, mode_q=0.
  - An in-flight beat is dropped.
- Two-state FSM encoded by out_valid: EMPTY (out_valid=0) and FULL (out_valid=1).
- Capture condition: cap = en && (!out_valid || out_ready).
  - A beat is accepted and a new one captured in the same cycle (full throughput).
- On cap:
  - Index src = mode ? ptr : sel.
  - out_data <= data_in[src*W +: W], out_sel <= src, out_valid <= 1.
  - Latency: 1 clock from capture edge to out_valid.
- FULL && out_ready && !cap: out_valid <= 0 (FULL -> EMPTY).
- FULL && !out_ready: out_data and out_sel hold stable; data_in changes are ignored.
- Manual capture with sel >= NCH (only possible when NCH is not a power of two):
  - out_data <= 0, out_sel <= sel, out_valid <= 1.
  - sel_err pulses high for exactly one cycle, coincident with the capture edge.
- Scan pointer:
  - ptr advances on each scan-mode capture: ptr <= (ptr == NCH-1) ? 0 : ptr+1. Wrap is explicit, not a power-of-two rollover.
  - ptr holds in manual mode.
- Mode switch:
  - mode_q registers mode.
  - On a 0->1 transition (mode && !mode_q), ptr is forced to 0 that cycle.
  - If cap is also true that cycle, it captures channel 0, and ptr then becomes 1.
- en=0: no capture; a pending FULL beat can still drain.
- All arithmetic is unsigned. No combinational path from data_in to out_data.

Optional Feature:
- Macro SCAN_MUX_PARITY_EN.
- Defined:
  - Extra output port out_par (1 bit) = even parity, ^out_data.
  - Registered alongside out_data; reset value 0.
  - Holds while stalled.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package scan_mux_pkg holds:
  - mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1;
  - default NCH/W localparams;
  - a function to compute the wrap of the next pointer.
- One sub-module, scan_mux_ptr:
  - the wrap counter, with inputs clk, rst_n, adv, clr and output ptr;
  - parametrised by NCH.
- The mux datapath and handshake stay in the top.

Test Plan (NCH=4, W=4, data_in={4'd8,4'd7,4'd5,4'd1}, i.e. ch0=1, ch1=5, ch2=7, ch3=8):
- Reset mid-beat: rst_n low while out_valid=1 -> out_valid, out_data and out_sel are 0 immediately, without waiting for a clock edge.
- Manual sweep, out_ready=1, en=1, sel=0,1,2,3 on successive cycles -> out_data=1,5,7,8 and out_sel=0,1,2,3, each 1 cycle later, out_valid held 1.
- Stall: out_ready=0 after the first capture (sel=2), then sel changes to 3 -> out_data stays 7 and out_sel stays 2 until out_ready=1. The next beat is then 8.
- Scan wrap: mode rises 0->1 with en=1, out_ready=1, for 6 cycles -> out_sel=0,1,2,3,0,1 and out_data=1,5,7,8,1,5.
- Scan stall: out_ready=0 for 3 cycles mid-scan -> ptr does not advance, no channel is skipped, and out_sel resumes in sequence.
- NCH=3 build, manual sel=3 -> out_data=0, out_sel=3, sel_err high for 1 cycle.
- With SCAN_MUX_PARITY_EN: out_data=7 -> out_par=1; out_data=5 -> out_par=0.
